// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DIV_WIDTH   : default operand/result width
//   div_state_e : controller state encoding
//   cnt_width() : width of the iteration counter for a given operand width
package div_pkg;

  localparam int unsigned DIV_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SHIFT    = 3'd2,
    SUBTRACT = 3'd3,
    FIXSIGN  = 3'd4,
    DONE     = 3'd5
  } div_state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle of the divider.
//   start, dividend, divisor                      : requester -> divider
//   quotient, remainder, busy, done, div_by_zero,
//   overflow                                      : divider -> requester
// master = requester side, slave = divider side.
interface seq_restoring_divider_if
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_div_datapath.sv
// Datapath of the restoring divider: operand capture, A/Q/M/count registers,
// the A - M subtractor and the sign-corrected result registers.
//   i_capture               : latch raw operands (accepting IDLE cycle)
//   i_load                  : set up A/Q/M/count from magnitudes
//   i_shift_en / i_sub_en   : one half of an iteration each
//   i_fix_en                : write sign-corrected quotient/remainder
//   i_dbz_load              : write divide-by-zero result
//   o_count_zero            : the pending decrement brings count to zero
//   o_sub_neg               : A - M is negative (restore)
//   o_divisor_zero          : captured divisor is zero
//   o_ovf_cond              : captured operands are MIN / -1
module seq_div_datapath
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_capture,
  input  logic             i_load,
  input  logic             i_shift_en,
  input  logic             i_sub_en,
  input  logic             i_fix_en,
  input  logic             i_dbz_load,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_count_zero,
  output logic             o_sub_neg,
  output logic             o_divisor_zero,
  output logic             o_ovf_cond,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);
  localparam int unsigned      CW  = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] r_dvd, r_dvs;
  logic [WIDTH:0]   r_a;
  logic [WIDTH-1:0] r_q, r_m;
  logic [CW-1:0]    r_cnt;
  logic             r_sd, r_sv;
  logic [WIDTH-1:0] r_quo, r_rem;

  logic [WIDTH:0]   w_t;
  logic [WIDTH-1:0] w_abs_dvd, w_abs_dvs;

  // Magnitudes as unsigned WIDTH bits: -MIN wraps to MIN, which is |MIN|.
  assign w_abs_dvd = r_dvd[WIDTH-1] ? -r_dvd : r_dvd;
  assign w_abs_dvs = r_dvs[WIDTH-1] ? -r_dvs : r_dvs;

  // A < M <= 2^(WIDTH-1) before the shift, so |T| < 2^WIDTH and the MSB is the sign.
  assign w_t       = r_a - {1'b0, r_m};
  assign o_sub_neg = w_t[WIDTH];

  assign o_count_zero   = (r_cnt == CW'(1));
  assign o_divisor_zero = (r_dvs == '0);
  assign o_ovf_cond     = (r_dvd == MIN) && (r_dvs == '1);
  assign o_quotient     = r_quo;
  assign o_remainder    = r_rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_a   <= '0;
      r_q   <= '0;
      r_m   <= '0;
      r_cnt <= '0;
      r_sd  <= 1'b0;
      r_sv  <= 1'b0;
      r_quo <= '0;
      r_rem <= '0;
    end else begin
      if (i_capture) begin
        r_dvd <= i_dividend;
        r_dvs <= i_divisor;
      end
      if (i_load) begin
        r_a   <= '0;
        r_q   <= w_abs_dvd;
        r_m   <= w_abs_dvs;
        r_cnt <= CW'(WIDTH);
        r_sd  <= r_dvd[WIDTH-1];
        r_sv  <= r_dvs[WIDTH-1];
      end
      if (i_shift_en) begin
        {r_a, r_q} <= {r_a[WIDTH-1:0], r_q, 1'b0};
      end
      if (i_sub_en) begin
        if (!o_sub_neg) r_a <= w_t;
        r_q[0] <= ~o_sub_neg;
        r_cnt  <= r_cnt - CW'(1);
      end
      if (i_fix_en) begin
        r_quo <= (r_sd ^ r_sv) ? -r_q : r_q;
        r_rem <= r_sd ? -r_a[WIDTH-1:0] : r_a[WIDTH-1:0];
      end
      if (i_dbz_load) begin
        r_quo <= '1;
        r_rem <= r_dvd;
      end
    end
  end
endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential signed restoring divider (truncating quotient, remainder takes
// the dividend's sign). Controller FSM and status flags live here; the
// arithmetic lives in seq_div_datapath.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : start/operands in; quotient/remainder/busy/done/
//                div_by_zero/overflow out
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic                    clk,
  input logic                    rst_n,
  seq_restoring_divider_if.slave bus
);
  div_state_e r_state;
  logic       r_busy, r_done, r_dbz, r_ovf;

  logic             w_capture, w_load, w_shift_en, w_sub_en, w_fix_en, w_dbz_load;
  logic             w_count_zero, w_sub_neg, w_divisor_zero, w_ovf_cond;
  logic [WIDTH-1:0] w_quotient, w_remainder;

  assign w_capture  = (r_state == IDLE) && bus.start;
  assign w_load     = (r_state == LOAD) && !w_divisor_zero;
  assign w_dbz_load = (r_state == LOAD) && w_divisor_zero;
  assign w_shift_en = (r_state == SHIFT);
  assign w_sub_en   = (r_state == SUBTRACT);
  assign w_fix_en   = (r_state == FIXSIGN);

  seq_div_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_capture     (w_capture),
    .i_load        (w_load),
    .i_shift_en    (w_shift_en),
    .i_sub_en      (w_sub_en),
    .i_fix_en      (w_fix_en),
    .i_dbz_load    (w_dbz_load),
    .i_dividend    (bus.dividend),
    .i_divisor     (bus.divisor),
    .o_count_zero  (w_count_zero),
    .o_sub_neg     (w_sub_neg),
    .o_divisor_zero(w_divisor_zero),
    .o_ovf_cond    (w_ovf_cond),
    .o_quotient    (w_quotient),
    .o_remainder   (w_remainder)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_state <= LOAD;
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        LOAD: begin
          if (w_divisor_zero) begin
            r_dbz   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_state <= SHIFT;
          end
        end
        SHIFT:    r_state <= SUBTRACT;
        // count_zero looks at the value before this cycle's decrement.
        SUBTRACT: r_state <= w_count_zero ? FIXSIGN : SHIFT;
        FIXSIGN: begin
          r_ovf   <= w_ovf_cond;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.quotient    = w_quotient;
  assign bus.remainder   = w_remainder;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;
endmodule
